// File: rtl/pu_pkg.sv
// Shared constants, RAM select codes and FSM state type for the processing-unit datapath.
package pu_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int PROD_W     = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = 26;
    localparam int RAMDATA_W  = 21;
    localparam int MEMSEL_W   = 6;
    localparam int REGSEL_W   = 14;
    localparam int CNT_W      = 10;

    localparam logic [2:0]          IM_DSTSEL_SIG1 = 3'b010;
    localparam logic [2:0]          IM_DSTSEL_SIG2 = 3'b011;
    localparam logic [3:0]          SIG_RAM_ADR    = 4'b0010;
    localparam logic [MEMSEL_W-1:0] ACC_RAM_ADR    = 6'h03;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_PUSH  = 2'd2,
        ST_HOLD  = 2'd3
    } acc_state_e;

    // Rail value of the accumulator in the direction of the given sign.
    function automatic logic [ACC_WIDTH-1:0] acc_rail(input logic neg);
        if (neg) begin
            acc_rail = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            acc_rail = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/sat_add.sv
// Signed two's-complement adder that clamps to the representable range and flags the clamp.
module sat_add #(
    parameter int WIDTH = 26
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             sat
);

    logic [WIDTH:0] wide_s;

    assign wide_s = {a[WIDTH-1], a} + {b[WIDTH-1], b};

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        sum = wide_s[WIDTH-1:0];
        sat = 1'b0;
        if (wide_s[WIDTH] != wide_s[WIDTH-1]) begin
            sat = 1'b1;
            sum = wide_s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sat = 1'b0;
            sum = wide_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pu_accumulator.sv
// Per-neuron signed MAC with bias add, feeding one saturated 26-bit result per neuron
// into the sigmoid input FIFO with full back-pressure.
module pu_accumulator
    import pu_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [2:0]            mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_w,
    input  logic                  in_last,
    input  logic                  acc_full,
    output logic [ACC_WIDTH-1:0]  acc_dout,
    output logic                  acc_enq,
    output logic [2:0]            acc_mode,
    output logic                  acc_sat,
    input  logic [RAMDATA_W-1:0]  ram_din,
    input  logic [REGSEL_W-1:0]   ram_reg_adr,
    input  logic [MEMSEL_W-1:0]   ram_mem_adr,
    input  logic                  ram_we
);

    acc_state_e             state_r, state_next_s;
    logic                   in_ready_s, enq_s, accept_s, pending_s;
    logic                   out_busy_s, blocked_s, p2_fire_s, finish_s;
    logic [CNT_W-1:0]       cnt_r;
    logic                   first_s, force_s, eff_last_s;
    logic [PROD_W-1:0]      a_ext_s, w_ext_s, prod_s;

    logic                   p1_valid_r, p1_first_r, p1_last_r, p1_force_r, p1_load_s;
    logic [PROD_W-1:0]      p1_prod_r;
    logic [2:0]             p1_mode_r;

    logic [ACC_WIDTH-1:0]   prod_ext_s, term_sum_s, acc_next_s, acc_r;
    logic                   term_sat_s, sat_next_s, sat_r;
    logic [2:0]             mode_r, res_mode_s;
    logic [RAMDATA_W-1:0]   bias_r;
    logic [ACC_WIDTH-1:0]   bias_ext_s, fin_sum_s, res_s;
    logic                   fin_sat_s, res_sat_s;

    logic [ACC_WIDTH-1:0]   out_dout_r;
    logic [2:0]             out_mode_r;
    logic                   out_sat_r;
    logic                   unused_s;

    assign unused_s = ^ram_reg_adr;

    // Result register is occupied and the FIFO cannot take it this cycle.
    assign out_busy_s = (state_r == ST_PUSH) || (state_r == ST_HOLD);
    assign blocked_s  = out_busy_s && acc_full;
    assign in_ready_s = !((state_r == ST_HOLD) || ((state_r == ST_PUSH) && acc_full));
    assign enq_s      = out_busy_s && !acc_full;
    assign accept_s   = in_valid && in_ready_s;

    assign first_s    = (cnt_r == {CNT_W{1'b0}});
    assign force_s    = (cnt_r == {CNT_W{1'b1}}) && !in_last;
    assign eff_last_s = in_last || force_s;

    assign a_ext_s = {{(PROD_W-DATA_WIDTH){din_a[DATA_WIDTH-1]}}, din_a};
    assign w_ext_s = {{(PROD_W-DATA_WIDTH){din_w[DATA_WIDTH-1]}}, din_w};
    assign prod_s  = a_ext_s * w_ext_s;

    // A finishing term waits in P1 while the previous result is still stuck on a full FIFO.
    assign p2_fire_s = p1_valid_r && !(p1_last_r && blocked_s);
    assign finish_s  = p2_fire_s && p1_last_r;
    assign p1_load_s = p2_fire_s || !p1_valid_r;
    assign pending_s = accept_s || p1_valid_r || !first_s;

    // Terms seen so far in the current neuron; zero marks the next term as a first term.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= eff_last_s ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // P1: registered product with its neuron framing flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            p1_valid_r <= 1'b0;
            p1_prod_r  <= {PROD_W{1'b0}};
            p1_first_r <= 1'b0;
            p1_last_r  <= 1'b0;
            p1_force_r <= 1'b0;
            p1_mode_r  <= 3'd0;
        end else if (p1_load_s) begin
            p1_valid_r <= accept_s;
            p1_prod_r  <= prod_s;
            p1_first_r <= first_s;
            p1_last_r  <= eff_last_s;
            p1_force_r <= force_s;
            p1_mode_r  <= mode;
        end
    end

    assign prod_ext_s = {{(ACC_WIDTH-PROD_W){p1_prod_r[PROD_W-1]}}, p1_prod_r};
    assign bias_ext_s = {{(ACC_WIDTH-RAMDATA_W){bias_r[RAMDATA_W-1]}}, bias_r};

    sat_add #(.WIDTH(ACC_WIDTH)) u_add_term (
        .a   (acc_r),
        .b   (prod_ext_s),
        .sum (term_sum_s),
        .sat (term_sat_s)
    );

    sat_add #(.WIDTH(ACC_WIDTH)) u_add_bias (
        .a   (acc_next_s),
        .b   (bias_ext_s),
        .sum (fin_sum_s),
        .sat (fin_sat_s)
    );

    // P2 datapath: restart or extend the running sum, then form the biased result.
    always_comb begin
        acc_next_s = term_sum_s;
        sat_next_s = sat_r;
        res_s      = fin_sum_s;
        res_sat_s  = 1'b0;
        res_mode_s = p1_first_r ? p1_mode_r : mode_r;
        if (p1_first_r) begin
            acc_next_s = prod_ext_s;
            sat_next_s = 1'b0;
        end else begin
            acc_next_s = term_sum_s;
            sat_next_s = sat_r | term_sat_s;
        end
        // Running out of term slots is reported as saturation toward the sum's sign.
        if (p1_force_r) begin
            res_s     = acc_rail(acc_next_s[ACC_WIDTH-1]);
            res_sat_s = 1'b1;
        end else begin
            res_s     = fin_sum_s;
            res_sat_s = sat_next_s | fin_sat_s;
        end
    end

    // P2 accumulator, sticky saturation and neuron mode.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acc_r  <= {ACC_WIDTH{1'b0}};
            sat_r  <= 1'b0;
            mode_r <= 3'd0;
        end else if (p2_fire_s) begin
            acc_r  <= acc_next_s;
            sat_r  <= sat_next_s;
            mode_r <= res_mode_s;
        end
    end

    // Bias register written through the shared RAM write port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bias_r <= {RAMDATA_W{1'b0}};
        end else if (ram_we && (ram_mem_adr == ACC_RAM_ADR)) begin
            bias_r <= ram_din;
        end
    end

    // Result register held stable until the FIFO takes it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_dout_r <= {ACC_WIDTH{1'b0}};
            out_mode_r <= 3'd0;
            out_sat_r  <= 1'b0;
        end else if (finish_s) begin
            out_dout_r <= res_s;
            out_mode_r <= res_mode_s;
            out_sat_r  <= res_sat_s;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (finish_s) begin
                    state_next_s = ST_PUSH;
                end else if (accept_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                state_next_s = finish_s ? ST_PUSH : ST_ACCUM;
            end
            ST_PUSH, ST_HOLD: begin
                if (acc_full) begin
                    state_next_s = ST_HOLD;
                end else if (finish_s) begin
                    state_next_s = ST_PUSH;
                end else if (pending_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign in_ready = in_ready_s;
    assign acc_enq  = enq_s;
    assign acc_dout = out_dout_r;
    assign acc_mode = out_mode_r;
    assign acc_sat  = out_sat_r;

endmodule

// File: tb/tb_pu_accumulator.sv
// Self-checking bench for pu_accumulator: directed scenarios plus randomized neurons
// scored against an arithmetic model of the dot-product/bias/saturation rules.
module tb_pu_accumulator;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [2:0]  mode;
    logic        in_valid, in_ready, in_last;
    logic [7:0]  din_a, din_w;
    logic        acc_full, acc_enq, acc_sat;
    logic [25:0] acc_dout;
    logic [2:0]  acc_mode;
    logic [20:0] ram_din;
    logic [13:0] ram_reg_adr;
    logic [5:0]  ram_mem_adr;
    logic        ram_we;

    logic        full_rand_en = 1'b0;
    logic        full_req     = 1'b0;
    logic        rnd_full     = 1'b0;
    assign acc_full = full_rand_en ? rnd_full : full_req;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct {
        logic [25:0] dout;
        logic [2:0]  mode;
        logic        sat;
    } res_t;

    res_t        exp_q[$];
    logic [25:0] obs_q[$];

    localparam longint MAXV = 64'sd33554431;
    localparam longint MINV = -64'sd33554432;

    longint      m_sum  = 0;
    longint      m_bias = 0;
    int          m_cnt  = 0;
    bit          m_sat  = 1'b0;
    logic [2:0]  m_mode = 3'd0;

    pu_accumulator dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din_a       (din_a),
        .din_w       (din_w),
        .in_last     (in_last),
        .acc_full    (acc_full),
        .acc_dout    (acc_dout),
        .acc_enq     (acc_enq),
        .acc_mode    (acc_mode),
        .acc_sat     (acc_sat),
        .ram_din     (ram_din),
        .ram_reg_adr (ram_reg_adr),
        .ram_mem_adr (ram_mem_adr),
        .ram_we      (ram_we)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: accepted terms and pushed results, observed mid-cycle.
    always @(negedge CLK) begin
        longint prod;
        longint v;
        res_t   r;
        if (!RST_N) begin
            m_sum = 0; m_cnt = 0; m_sat = 1'b0; m_bias = 0; m_mode = 3'd0;
            exp_q.delete();
        end else begin
            if (acc_enq) begin
                check_val("enq_while_full", {63'd0, acc_full}, 64'd0);
                obs_q.push_back(acc_dout);
                check_val("enq_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check_val("dout", {38'd0, acc_dout}, {38'd0, r.dout});
                    check_val("mode", {61'd0, acc_mode}, {61'd0, r.mode});
                    check_val("sat",  {63'd0, acc_sat},  {63'd0, r.sat});
                end
            end
            if (ram_we && ram_mem_adr == 6'h03) begin
                m_bias = longint'($signed(ram_din));
            end
            if (in_valid && in_ready) begin
                prod = longint'($signed(din_a)) * longint'($signed(din_w));
                if (m_cnt == 0) begin
                    m_sum = prod; m_sat = 1'b0; m_mode = mode;
                end else begin
                    m_sum = m_sum + prod;
                    if (m_sum > MAXV) begin m_sum = MAXV; m_sat = 1'b1; end
                    if (m_sum < MINV) begin m_sum = MINV; m_sat = 1'b1; end
                end
                m_cnt++;
                if (in_last || m_cnt == 1024) begin
                    r.mode = m_mode;
                    if (!in_last) begin
                        v = (m_sum < 0) ? MINV : MAXV;
                        r.sat = 1'b1;
                    end else begin
                        v = m_sum + m_bias;
                        r.sat = m_sat;
                        if (v > MAXV) begin v = MAXV; r.sat = 1'b1; end
                        if (v < MINV) begin v = MINV; r.sat = 1'b1; end
                    end
                    r.dout = v[25:0];
                    exp_q.push_back(r);
                    m_cnt = 0;
                end
            end
        end
    end

    // Random back-pressure source, enabled only during the random phase.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            rnd_full = ($urandom_range(0, 9) < 3);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_term(input logic [7:0] a, input logic [7:0] w, input logic last,
                             input logic [2:0] md, output int waited);
        logic accepted;
        accepted = 1'b0;
        waited   = 0;
        din_a = a; din_w = w; in_last = last; mode = md; in_valid = 1'b1;
        for (int i = 0; i < 400 && !accepted; i++) begin
            @(negedge CLK);
            if (in_ready) accepted = 1'b1;
            else waited++;
            @(posedge CLK);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!accepted) check_val("accept_timeout", {63'd0, accepted}, 64'd1);
    endtask

    task automatic write_bias(input logic [20:0] v, input logic [5:0] adr);
        ram_din = v; ram_mem_adr = adr; ram_we = 1'b1;
        @(posedge CLK);
        #1;
        ram_we = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge CLK);
            #1;
            i++;
        end
        check_val("drain", exp_q.size(), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge CLK);
        check_val({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        check_val({tag, "_enq"},      {63'd0, acc_enq},  64'd0);
        check_val({tag, "_dout"},     {38'd0, acc_dout}, 64'd0);
        check_val({tag, "_mode"},     {61'd0, acc_mode}, 64'd0);
        check_val({tag, "_sat"},      {63'd0, acc_sat},  64'd0);
    endtask

    initial begin
        int w0, w1, w2;
        int nterms;
        logic [2:0] md;

        RST_N = 1'b0; mode = 3'd0; in_valid = 1'b0; in_last = 1'b0;
        din_a = 8'd0; din_w = 8'd0; ram_din = 21'd0; ram_reg_adr = 14'd0;
        ram_mem_adr = 6'd0; ram_we = 1'b0;
        repeat (3) @(posedge CLK);
        check_reset_outputs("reset");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;

        // 1: three-term neuron, latency and mode capture
        send_term(8'd2, 8'd3, 1'b0, 3'b011, w0);
        send_term(8'd4, 8'd5, 1'b0, 3'b000, w0);
        send_term(8'hFF, 8'd6, 1'b1, 3'b000, w0);
        @(negedge CLK);
        check_val("t1_enq_early", {63'd0, acc_enq}, 64'd0);
        @(negedge CLK);
        check_val("t1_enq", {63'd0, acc_enq}, 64'd1);
        check_val("t1_dout", {38'd0, acc_dout}, 64'd20);
        check_val("t1_mode", {61'd0, acc_mode}, 64'd3);
        check_val("t1_sat", {63'd0, acc_sat}, 64'd0);
        @(posedge CLK);
        #1;

        // 2: negative bias, foreign address ignored, single-term neuron
        write_bias(21'h1FFFF6, 6'h03);
        write_bias(21'h000123, 6'h02);
        send_term(8'd10, 8'd10, 1'b1, 3'b010, w0);
        @(negedge CLK);
        @(negedge CLK);
        check_val("t2_enq", {63'd0, acc_enq}, 64'd1);
        check_val("t2_dout", {38'd0, acc_dout}, 64'd90);
        @(negedge CLK);
        check_val("t2_single_pulse", {63'd0, acc_enq}, 64'd0);
        @(posedge CLK);
        #1;

        // 3: 1023 terms then forced finish on the 1024th, then a fresh neuron
        obs_q.delete();
        for (int i = 0; i < 1023; i++) send_term(8'h80, 8'h80, 1'b0, 3'b010, w0);
        check_val("t3_no_early_enq", obs_q.size(), 64'd0);
        send_term(8'h80, 8'h80, 1'b0, 3'b010, w0);
        @(negedge CLK);
        @(negedge CLK);
        check_val("t3_force_enq", {63'd0, acc_enq}, 64'd1);
        check_val("t3_force_dout", {38'd0, acc_dout}, 64'h1FFFFFF);
        check_val("t3_force_sat", {63'd0, acc_sat}, 64'd1);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 798; i++) send_term(8'h80, 8'h80, 1'b0, 3'b011, w0);
        send_term(8'h80, 8'h80, 1'b1, 3'b011, w0);
        wait_drain(20);

        // 4: result held against a full FIFO
        full_req = 1'b1;
        send_term(8'd3, 8'hFC, 1'b1, 3'b001, w0);
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check_val("t4_hold_enq", {63'd0, acc_enq}, 64'd0);
            check_val("t4_hold_ready", {63'd0, in_ready}, 64'd0);
            check_val("t4_hold_dout", {38'd0, acc_dout}, 64'h3FFFFEA);
        end
        @(posedge CLK);
        #1;
        full_req = 1'b0;
        @(negedge CLK);
        check_val("t4_release_enq", {63'd0, acc_enq}, 64'd1);
        check_val("t4_release_dout", {38'd0, acc_dout}, 64'h3FFFFEA);
        @(negedge CLK);
        check_val("t4_ready_after", {63'd0, in_ready}, 64'd1);
        check_val("t4_no_second_enq", {63'd0, acc_enq}, 64'd0);
        @(posedge CLK);
        #1;

        // 5: back-to-back neurons with zero bias
        write_bias(21'd0, 6'h03);
        obs_q.delete();
        send_term(8'd1, 8'd1, 1'b1, 3'b010, w0);
        send_term(8'd2, 8'd2, 1'b0, 3'b011, w1);
        send_term(8'd3, 8'd3, 1'b1, 3'b011, w2);
        check_val("t5_no_stall", w0 + w1 + w2, 64'd0);
        repeat (4) @(negedge CLK);
        check_val("t5_count", obs_q.size(), 64'd2);
        if (obs_q.size() == 2) begin
            check_val("t5_first", {38'd0, obs_q[0]}, 64'd1);
            check_val("t5_second", {38'd0, obs_q[1]}, 64'd13);
        end
        @(posedge CLK);
        #1;

        // 6: reset mid-neuron discards the partial sum
        send_term(8'd1, 8'd2, 1'b0, 3'b010, w0);
        send_term(8'd3, 8'd4, 1'b0, 3'b010, w0);
        RST_N = 1'b0;
        check_reset_outputs("t6_reset");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        obs_q.delete();
        send_term(8'd7, 8'd7, 1'b1, 3'b001, w0);
        repeat (3) @(negedge CLK);
        check_val("t6_count", obs_q.size(), 64'd1);
        if (obs_q.size() == 1) check_val("t6_dout", {38'd0, obs_q[0]}, 64'd49);
        @(posedge CLK);
        #1;

        // Random neurons under random back-pressure and bias changes
        full_rand_en = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (n % 10 == 0) begin
                wait_drain(500);
                write_bias(21'($urandom_range(0, 2097151)), 6'h03);
            end
            nterms = $urandom_range(1, 12);
            md = 3'($urandom_range(0, 7));
            for (int t = 0; t < nterms; t++) begin
                send_term(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          (t == nterms - 1), md, w0);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge CLK);
                    #1;
                end
            end
        end
        full_rand_en = 1'b0;
        full_req     = 1'b0;
        wait_drain(500);
        repeat (3) @(posedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
